rvc_asap_cr_ctrl: RTL and testbench
===================================

# rvc_asap_cr_ctrl

- Parametrised control-register (CR) block for the rvc_asap core.
- Decodes data-memory accesses in the CR window (0x7000–0x7FFF) and drives a configurable number of 7-segment displays, LEDs and VGA cursor registers.
- Synchronises and debounces buttons and switches.
- Captures button-press events into write-1-to-clear sticky bits that raise a maskable interrupt.
- Sits between the core's data-memory port and the board I/O pins, replacing the fixed-width CR register set.

## Interface
Parameters:
- NUM_SEG7, 6, number of 7-segment registers (1–16)
- LED_W, 10, LED register width (1–32)
- NUM_BTN, 2, number of buttons (1–32)
- SW_W, 10, switch width (1–32)
- DB_CNT_W, 16, debounce counter width
- DB_CYC, 50000, stable cycles required to accept a button change (< 2**DB_CNT_W)

Ports (reset is asynchronous, active-low):
- Clock  in  1  core clock
- RstN  in  1  asynchronous active-low reset
- CrAddr  in  16  byte address; block decodes CrAddr[15:12]==4'h7 and the word offset CrAddr[11:2]
- CrWrEn  in  1  write strobe
- CrRdEn  in  1  read strobe
- CrByteEn  in  4  write byte enables
- CrWrData  in  32  write data
- CrRdData  out  32  read data, registered
- Seg7  out  NUM_SEG7*8  segment drive, active-low, register i in bits [8i+7:8i]
- Led  out  LED_W  LED drive
- CursorH  out  32  VGA cursor horizontal
- CursorV  out  32  VGA cursor vertical
- ButtonIn  in  NUM_BTN  raw asynchronous buttons, active-high after board inversion
- SwitchIn  in  SW_W  raw asynchronous switches
- BtnIrq  out  1  registered interrupt request

## Operation
Register map (offset from 0x7000):
- 0x00+4i SEG7_i RW
- 0x40 LED RW
- 0x44 BTN_STATE RO, debounced
- 0x48 BTN_EVENT W1C
- 0x4C BTN_IRQ_EN RW
- 0x50 SWITCH RO, synchronised
- 0x54 CURSOR_H RW
- 0x58 CURSOR_V RW

Access rules:
- Fields are LSB-aligned; unused bits read 0. SEG7_i for i ≥ NUM_SEG7 is unmapped.
- Unmapped offset or CrAddr[15:12]≠7: reads return 0, writes are ignored.
- Writes honour CrByteEn. Writes to RO registers are ignored.

Input path:
- Every ButtonIn and SwitchIn bit passes a 2-flop synchroniser.

Debounce, per button:
- Counter clears whenever the synced value equals the debounced state.
- Otherwise it increments each cycle.
- When it reaches DB_CYC-1, the debounced state takes the synced value and the counter clears.

Events and interrupt:
- A debounced 0→1 transition sets BTN_EVENT[b].
- Writing 1 to a BTN_EVENT bit (byte-enabled) clears it.
- Set and clear in the same cycle: set wins.
- BtnIrq <= |(BTN_EVENT & BTN_IRQ_EN).

Reset values:
- Seg7 all 8'hFF (segments off).
- Led, CursorH, CursorV, CrRdData, BtnIrq: 0.
- BTN_EVENT, BTN_IRQ_EN, debounced state, counters and synchronisers: 0.

Reset asserted mid-operation returns every register to these values asynchronously. No access is in flight after reset.

## Timing
- Write commits at the clock edge where CrWrEn=1. The output pin changes the same edge.
- Read latency is 1 cycle: CrRdData is valid the cycle after CrRdEn and holds until the next CrRdEn.
- Read and write to the same address in the same cycle: the read returns the pre-write value. A read the next cycle returns the new value.
- Button path: 2 cycles sync + DB_CYC cycles stable, then the BTN_EVENT set edge, then BtnIrq one cycle later.
- Switch latency to the SWITCH register: 2 cycles.
- Clearing the last enabled event drops BtnIrq one cycle after the write edge.
- Counter wrap is impossible because it clears at DB_CYC-1.

## Configuration
- RVC_ASAP_CR_DEBOUNCE_EN defined: debounce counters present as described.
- Undefined: no counters. The debounced state is the synchroniser output delayed by one flop (3-cycle latency); event and IRQ logic are unchanged.

## Structure
- rvc_asap_pkg holds:
  - the CR base and offset constants (CR_SEG7_BASE, CR_LED, CR_BTN_STATE, CR_BTN_EVENT, CR_BTN_IRQ_EN, CR_SWITCH, CR_CURSOR_H, CR_CURSOR_V);
  - t_cr_rw and t_cr_ro, generalised with package parameters for field widths.
- Sub-module rvc_asap_debounce (one per button, generate loop) contains the synchroniser, counter and stable state, and outputs a rise pulse.
- Switches use synchroniser flops only.

## Test plan
- Reset, then read all offsets: SEG7_0..5 = 0xFF, all other registers = 0, BtnIrq = 0.
- Write 0x7000 data 0xA5 with CrByteEn=4'b0001: Seg7[7:0]=0xA5 the same edge. Read the next cycle returns 0x000000A5. Write 0x7004 with CrByteEn=0: Seg7[15:8] stays 0xFF.
- DB_CYC=8: pulse ButtonIn[0] high for 5 cycles (bounce), then hold high for 20 cycles. BTN_STATE[0] rises exactly 2+8 cycles after the stable high; BTN_EVENT[0] is set and there is no event from the bounce.
- BTN_IRQ_EN=1, event pending: BtnIrq=1. Write 1 to BTN_EVENT in the same cycle as a new button-0 rise: bit stays set. Clear again: BtnIrq=0 one cycle later.
- Access 0x705C and 0x8000: reads return 0 and writes change no output.
- Rebuild without RVC_ASAP_CR_DEBOUNCE_EN: a button rise is reflected in BTN_STATE 3 cycles later.

Source files
------------

// File: rtl/rvc_asap_pkg.sv
// Shared constants and register-file types for the rvc_asap control-register block.
package rvc_asap_pkg;

    localparam logic [3:0]  CR_REGION     = 4'h7;
    localparam int unsigned CR_MAX_SEG7   = 16;
    localparam int unsigned CR_FIELD_W    = 32;

    localparam logic [11:0] CR_SEG7_BASE  = 12'h000;
    localparam logic [11:0] CR_LED        = 12'h040;
    localparam logic [11:0] CR_BTN_STATE  = 12'h044;
    localparam logic [11:0] CR_BTN_EVENT  = 12'h048;
    localparam logic [11:0] CR_BTN_IRQ_EN = 12'h04C;
    localparam logic [11:0] CR_SWITCH     = 12'h050;
    localparam logic [11:0] CR_CURSOR_H   = 12'h054;
    localparam logic [11:0] CR_CURSOR_V   = 12'h058;

    // Fields are sized for the largest configuration; the top masks them down to the real width.
    typedef struct packed {
        logic [CR_MAX_SEG7-1:0][7:0] seg7;
        logic [CR_FIELD_W-1:0]       led;
        logic [CR_FIELD_W-1:0]       btn_irq_en;
        logic [CR_FIELD_W-1:0]       cursor_h;
        logic [CR_FIELD_W-1:0]       cursor_v;
    } t_cr_rw;

    typedef struct packed {
        logic [CR_FIELD_W-1:0] btn_state;
        logic [CR_FIELD_W-1:0] sw;
    } t_cr_ro;

    localparam t_cr_rw CR_RW_RST = t_cr_rw'({{CR_MAX_SEG7{8'hFF}}, {(4*CR_FIELD_W){1'b0}}});

    function automatic logic [31:0] cr_byte_mask(input logic [3:0] be);
        for (int i = 0; i < 4; i++) cr_byte_mask[8*i +: 8] = {8{be[i]}};
    endfunction

    function automatic logic [31:0] cr_field_mask(input int unsigned width);
        cr_field_mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    endfunction

    function automatic logic [31:0] cr_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] be, input int unsigned width);
        logic [31:0] m;
        m = cr_byte_mask(be);
        cr_merge = ((new_v & m) | (old_v & ~m)) & cr_field_mask(width);
    endfunction

endpackage

// File: rtl/rvc_asap_cr_ctrl_if.sv
// Data-memory side bus between the rvc_asap core and the control-register block.
interface rvc_asap_cr_ctrl_if;
    logic [15:0] CrAddr;
    logic        CrWrEn;
    logic        CrRdEn;
    logic [3:0]  CrByteEn;
    logic [31:0] CrWrData;
    logic [31:0] CrRdData;

    modport master (output CrAddr, CrWrEn, CrRdEn, CrByteEn, CrWrData, input CrRdData);
    modport slave  (input CrAddr, CrWrEn, CrRdEn, CrByteEn, CrWrData, output CrRdData);
endinterface

// File: rtl/rvc_asap_debounce.sv
// Per-button 2-flop synchroniser plus debounced state and rise pulse.
// RVC_ASAP_CR_DEBOUNCE_EN selects the stability counter; otherwise the state is one flop behind the synchroniser.
module rvc_asap_debounce #(
    parameter int DB_CNT_W = 16,
    parameter int DB_CYC   = 50000
) (
    input  logic Clock,
    input  logic RstN,
    input  logic raw,
    output logic state,
    output logic rise
);
    logic sync1, sync2;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock or negedge RstN) begin
        if (!RstN) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

`ifdef RVC_ASAP_CR_DEBOUNCE_EN
    logic [DB_CNT_W-1:0] cnt;
    logic                accept;

    assign accept = (sync2 != state) && (cnt == DB_CNT_W'(DB_CYC - 1));
    assign rise   = accept & sync2;

    always_ff @(posedge Clock or negedge RstN) begin
        if (!RstN) begin
            cnt   <= '0;
            state <= 1'b0;
        end else begin
            if (sync2 == state || accept) cnt <= '0;
            else                          cnt <= cnt + DB_CNT_W'(1);
            if (accept) state <= sync2;
        end
    end
`else
    localparam int unused_db_cfg = DB_CYC + DB_CNT_W;

    assign rise = sync2 & ~state;

    always_ff @(posedge Clock or negedge RstN) begin
        if (!RstN) state <= 1'b0;
        else       state <= sync2;
    end
`endif

endmodule

// File: rtl/rvc_asap_cr_ctrl.sv
// Parametrised control-register block: 7-seg, LED, cursor, button and switch registers at 0x7000.
// RVC_ASAP_CR_DEBOUNCE_EN enables the per-button debounce counters.
module rvc_asap_cr_ctrl
    import rvc_asap_pkg::*;
#(
    parameter int NUM_SEG7 = 6,
    parameter int LED_W    = 10,
    parameter int NUM_BTN  = 2,
    parameter int SW_W     = 10,
    parameter int DB_CNT_W = 16,
    parameter int DB_CYC   = 50000
) (
    input  logic                  Clock,
    input  logic                  RstN,
    rvc_asap_cr_ctrl_if.slave     cr,
    output logic [NUM_SEG7*8-1:0] Seg7,
    output logic [LED_W-1:0]      Led,
    output logic [31:0]           CursorH,
    output logic [31:0]           CursorV,
    input  logic [NUM_BTN-1:0]    ButtonIn,
    input  logic [SW_W-1:0]       SwitchIn,
    output logic                  BtnIrq
);
    t_cr_rw             cr_rw, rw_next;
    t_cr_ro             cr_ro;
    logic [NUM_BTN-1:0] btn_state, btn_rise, btn_event, ev_clr;
    logic [SW_W-1:0]    sw_s1, sw_s2;
    logic [31:0]        rd_val;
    logic [11:0]        offset;
    logic [3:0]         seg7_idx;
    logic               in_region, seg7_hit, unused_addr_lsb;

    assign in_region       = (cr.CrAddr[15:12] == CR_REGION);
    assign offset          = {cr.CrAddr[11:2], 2'b00};
    assign seg7_idx        = offset[5:2];
    assign seg7_hit        = (offset[11:6] == CR_SEG7_BASE[11:6]) && (int'(seg7_idx) < NUM_SEG7);
    assign unused_addr_lsb = ^cr.CrAddr[1:0];

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        rvc_asap_debounce #(.DB_CNT_W(DB_CNT_W), .DB_CYC(DB_CYC)) u_db (
            .Clock (Clock),
            .RstN  (RstN),
            .raw   (ButtonIn[b]),
            .state (btn_state[b]),
            .rise  (btn_rise[b])
        );
    end

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        rw_next = cr_rw;
        ev_clr  = '0;
        if (cr.CrWrEn && in_region) begin
            if (seg7_hit) begin
                rw_next.seg7[seg7_idx] = 8'(cr_merge(32'(cr_rw.seg7[seg7_idx]), cr.CrWrData, cr.CrByteEn, 8));
            end else begin
                case (offset)
                    CR_LED:        rw_next.led        = cr_merge(cr_rw.led, cr.CrWrData, cr.CrByteEn, LED_W);
                    CR_BTN_IRQ_EN: rw_next.btn_irq_en = cr_merge(cr_rw.btn_irq_en, cr.CrWrData, cr.CrByteEn, NUM_BTN);
                    CR_CURSOR_H:   rw_next.cursor_h   = cr_merge(cr_rw.cursor_h, cr.CrWrData, cr.CrByteEn, 32);
                    CR_CURSOR_V:   rw_next.cursor_v   = cr_merge(cr_rw.cursor_v, cr.CrWrData, cr.CrByteEn, 32);
                    CR_BTN_EVENT:  ev_clr = NUM_BTN'(cr.CrWrData & cr_byte_mask(cr.CrByteEn));
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        cr_ro                        = '0;
        cr_ro.btn_state[NUM_BTN-1:0] = btn_state;
        cr_ro.sw[SW_W-1:0]           = sw_s2;
    end

    // Read mux sees pre-write state, so a same-cycle read/write returns the old value.
    always_comb begin
        rd_val = '0;
        if (in_region) begin
            if (seg7_hit) begin
                rd_val = 32'(cr_rw.seg7[seg7_idx]);
            end else begin
                case (offset)
                    CR_LED:        rd_val = cr_rw.led;
                    CR_BTN_STATE:  rd_val = cr_ro.btn_state;
                    CR_BTN_EVENT:  rd_val = 32'(btn_event);
                    CR_BTN_IRQ_EN: rd_val = cr_rw.btn_irq_en;
                    CR_SWITCH:     rd_val = cr_ro.sw;
                    CR_CURSOR_H:   rd_val = cr_rw.cursor_h;
                    CR_CURSOR_V:   rd_val = cr_rw.cursor_v;
                    default:       rd_val = '0;
                endcase
            end
        end
    end

    // NOTE: this is a handful of discrete registers, not a RAM, so all of it takes the reset values.
    always_ff @(posedge Clock or negedge RstN) begin
        if (!RstN) begin
            cr_rw       <= CR_RW_RST;
            btn_event   <= '0;
            BtnIrq      <= 1'b0;
            sw_s1       <= '0;
            sw_s2       <= '0;
            cr.CrRdData <= '0;
        end else begin
            cr_rw     <= rw_next;
            btn_event <= (btn_event & ~ev_clr) | btn_rise;
            BtnIrq    <= |(btn_event & cr_rw.btn_irq_en[NUM_BTN-1:0]);
            sw_s1     <= SwitchIn;
            sw_s2     <= sw_s1;
            if (cr.CrRdEn) cr.CrRdData <= rd_val;
        end
    end

    for (genvar i = 0; i < NUM_SEG7; i++) begin : g_seg7
        assign Seg7[8*i +: 8] = cr_rw.seg7[i];
    end

    assign Led     = cr_rw.led[LED_W-1:0];
    assign CursorH = cr_rw.cursor_h;
    assign CursorV = cr_rw.cursor_v;

endmodule

// File: tb/tb_rvc_asap_cr_ctrl.sv
// Directed bench for rvc_asap_cr_ctrl; expected button latency follows RVC_ASAP_CR_DEBOUNCE_EN.
module tb_rvc_asap_cr_ctrl;

    localparam int DB_CYC = 8;
`ifdef RVC_ASAP_CR_DEBOUNCE_EN
    localparam int STATE_LAT    = 2 + DB_CYC;
    localparam int BOUNCE_EVENT = 0;
`else
    localparam int STATE_LAT    = 3;
    localparam int BOUNCE_EVENT = 1;
`endif

    logic        Clock = 1'b0;
    logic        RstN  = 1'b0;
    logic [47:0] Seg7;
    logic [9:0]  Led;
    logic [31:0] CursorH, CursorV;
    logic [1:0]  ButtonIn;
    logic [9:0]  SwitchIn;
    logic        BtnIrq;
    logic [31:0] rdata;
    int          checks = 0;
    int          errors = 0;

    rvc_asap_cr_ctrl_if cr();

    rvc_asap_cr_ctrl #(
        .NUM_SEG7(6), .LED_W(10), .NUM_BTN(2), .SW_W(10), .DB_CNT_W(16), .DB_CYC(DB_CYC)
    ) dut (
        .Clock    (Clock),
        .RstN     (RstN),
        .cr       (cr),
        .Seg7     (Seg7),
        .Led      (Led),
        .CursorH  (CursorH),
        .CursorV  (CursorV),
        .ButtonIn (ButtonIn),
        .SwitchIn (SwitchIn),
        .BtnIrq   (BtnIrq)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus tasks are entered and left 1 time unit after a rising edge.
    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
        cr.CrAddr   = a;
        cr.CrWrData = d;
        cr.CrByteEn = be;
        cr.CrWrEn   = 1'b1;
        @(posedge Clock); #1;
        cr.CrWrEn   = 1'b0;
        cr.CrByteEn = 4'h0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [31:0] d);
        cr.CrAddr = a;
        cr.CrRdEn = 1'b1;
        @(posedge Clock); #1;
        cr.CrRdEn = 1'b0;
        d = cr.CrRdData;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        cr.CrAddr = '0; cr.CrWrData = '0; cr.CrByteEn = '0; cr.CrWrEn = 1'b0; cr.CrRdEn = 1'b0;
        ButtonIn = '0; SwitchIn = '0;
        repeat (3) @(posedge Clock);
        #3 RstN = 1'b1;
        @(posedge Clock); #1;

        check("rst_irq", BtnIrq, 1'b0);
        check("rst_rdata", cr.CrRdData, 32'h0);
        check("rst_seg7", Seg7, 48'hFFFF_FFFF_FFFF);
        check("rst_led", Led, 10'h0);
        for (int off = 0; off <= 'h5C; off += 4) begin
            rd(16'h7000 + 16'(off), rdata);
            check($sformatf("rst_rd_%0h", off), rdata, (off < 'h18) ? 32'hFF : 32'h0);
        end

        wr(16'h7000, 32'h1234_56A5, 4'b0001);
        check("seg0_pin", Seg7[7:0], 8'hA5);
        rd(16'h7000, rdata);
        check("seg0_rd", rdata, 32'h0000_00A5);
        wr(16'h7004, 32'h0000_0000, 4'b0000);
        check("seg1_no_be", Seg7[15:8], 8'hFF);
        wr(16'h7014, 32'h0000_003C, 4'b0001);
        check("seg5_pin", Seg7[47:40], 8'h3C);

        wr(16'h7040, 32'hFFFF_FFFF, 4'b0011);
        check("led_pin", Led, 10'h3FF);
        rd(16'h7040, rdata);
        check("led_rd_masked", rdata, 32'h3FF);

        cr.CrAddr = 16'h7040; cr.CrWrData = 32'h155; cr.CrByteEn = 4'hF;
        cr.CrWrEn = 1'b1; cr.CrRdEn = 1'b1;
        @(posedge Clock); #1;
        cr.CrWrEn = 1'b0; cr.CrRdEn = 1'b0; cr.CrByteEn = 4'h0;
        check("rw_same_old", cr.CrRdData, 32'h3FF);
        check("rw_same_pin", Led, 10'h155);
        rd(16'h7040, rdata);
        check("rw_next_new", rdata, 32'h155);

        wr(16'h7054, 32'hDEAD_BEEF, 4'b1010);
        check("cursor_h_be", CursorH, 32'hDE00_BE00);
        wr(16'h7058, 32'h1234_5678, 4'b1111);
        check("cursor_v", CursorV, 32'h1234_5678);

        wr(16'h7050, 32'hFFFF_FFFF, 4'hF);
        rd(16'h7050, rdata);
        check("ro_switch_wr", rdata, 32'h0);
        wr(16'h7044, 32'hFFFF_FFFF, 4'hF);
        rd(16'h7044, rdata);
        check("ro_state_wr", rdata, 32'h0);

        wr(16'h705C, 32'hFFFF_FFFF, 4'hF);
        wr(16'h8000, 32'h0000_0000, 4'hF);
        wr(16'h8040, 32'h0000_0000, 4'hF);
        wr(16'h8054, 32'h0000_0000, 4'hF);
        wr(16'h7018, 32'h0000_0000, 4'hF);
        check("unmap_seg7", Seg7, 48'h3CFF_FFFF_FFA5);
        check("unmap_led", Led, 10'h155);
        check("unmap_cur_h", CursorH, 32'hDE00_BE00);
        rd(16'h705C, rdata); check("unmap_rd_705c", rdata, 32'h0);
        rd(16'h8000, rdata); check("unmap_rd_8000", rdata, 32'h0);
        rd(16'h8054, rdata); check("unmap_rd_8054", rdata, 32'h0);
        rd(16'h7018, rdata); check("unmap_rd_7018", rdata, 32'h0);

        cr.CrAddr = 16'h7050; cr.CrRdEn = 1'b1; SwitchIn = 10'h2A5;
        repeat (2) @(posedge Clock); #1;
        check("sw_lat_early", cr.CrRdData, 32'h0);
        @(posedge Clock); #1;
        check("sw_lat", cr.CrRdData, 32'h2A5);
        cr.CrRdEn = 1'b0;

        ButtonIn[0] = 1'b1;
        repeat (5) @(posedge Clock); #1;
        ButtonIn[0] = 1'b0;
        repeat (20) @(posedge Clock); #1;
        rd(16'h7048, rdata);
        check("bounce_event", rdata, 32'(BOUNCE_EVENT));
        wr(16'h7048, 32'h1, 4'b0001);
        rd(16'h7048, rdata);
        check("bounce_cleared", rdata, 32'h0);

        cr.CrAddr = 16'h7044; cr.CrRdEn = 1'b1; ButtonIn[0] = 1'b1;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge Clock); #1;
            if (lat < 0 && cr.CrRdData[0]) lat = n - 1;
        end
        cr.CrRdEn = 1'b0;
        check("btn_state_lat", lat, STATE_LAT);
        rd(16'h7044, rdata);
        check("btn_state", rdata, 32'h1);
        rd(16'h7048, rdata);
        check("btn_event", rdata, 32'h1);
        check("irq_masked", BtnIrq, 1'b0);

        wr(16'h704C, 32'h1, 4'b0001);
        check("irq_en_edge", BtnIrq, 1'b0);
        @(posedge Clock); #1;
        check("irq_set", BtnIrq, 1'b1);

        ButtonIn[0] = 1'b0;
        repeat (20) @(posedge Clock); #1;
        ButtonIn[0] = 1'b1;
        repeat (STATE_LAT - 1) @(posedge Clock); #1;
        cr.CrAddr = 16'h7048; cr.CrWrData = 32'h1; cr.CrByteEn = 4'b0001; cr.CrWrEn = 1'b1;
        @(posedge Clock); #1;
        cr.CrWrEn = 1'b0; cr.CrByteEn = 4'h0;
        rd(16'h7048, rdata);
        check("set_wins", rdata, 32'h1);
        check("irq_held", BtnIrq, 1'b1);

        wr(16'h7048, 32'h3, 4'b0001);
        check("irq_clr_edge", BtnIrq, 1'b1);
        @(posedge Clock); #1;
        check("irq_clr", BtnIrq, 1'b0);
        rd(16'h7048, rdata);
        check("event_clr", rdata, 32'h0);

        #2 RstN = 1'b0;
        #1;
        check("arst_seg7", Seg7, 48'hFFFF_FFFF_FFFF);
        check("arst_led", Led, 10'h0);
        check("arst_cur_h", CursorH, 32'h0);
        check("arst_rdata", cr.CrRdData, 32'h0);
        RstN = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
